// File: rtl/position_pd_control.sv
// PD position-loop controller: registered position error and its one-clock history feed
// a Kp/Kd correction that is scaled, clamped to +/-PWM_MAX and registered as the PWM command.
module position_pd_control #(
  parameter int PWM_MAX   = 7200,
  parameter int OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Sensor,
  input  logic [15:0] positon_target,
  input  logic [15:0] posi_kp,
  input  logic [15:0] posi_kd,
  output logic [15:0] Position_pwm
);

  // 40 bits covers the worst case |p + d| < 2^35 with margin.
  localparam int AW = 40;
  localparam logic signed [AW-1:0] SAT_HI = AW'(PWM_MAX);
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI;

  logic signed [16:0]   err_now;
  logic signed [16:0]   err_r;
  logic signed [16:0]   err_prev;
  logic signed [17:0]   err_diff;
  logic signed [16:0]   kp_s;
  logic signed [16:0]   kd_s;
  logic signed [AW-1:0] p_term;
  logic signed [AW-1:0] d_term;
  logic signed [AW-1:0] pd_sum;
  logic signed [AW-1:0] pd_scaled;
  logic [15:0]          pwm_next;

  always_comb begin
    err_now   = $signed({1'b0, Sensor}) - $signed({1'b0, positon_target});
    err_diff  = $signed({err_r[16], err_r}) - $signed({err_prev[16], err_prev});
    kp_s      = $signed({1'b0, posi_kp});
    kd_s      = $signed({1'b0, posi_kd});
    p_term    = AW'(err_r) * AW'(kp_s);
    d_term    = AW'(err_diff) * AW'(kd_s);
    pd_sum    = p_term + d_term;
    pd_scaled = pd_sum >>> OUT_SHIFT;
  end

  // Clamp against the full-width value so no wrapped result can slip through.
  always_comb begin
    pwm_next = pd_scaled[15:0];
    if (pd_scaled > SAT_HI) begin
      pwm_next = SAT_HI[15:0];
    end else if (pd_scaled < SAT_LO) begin
      pwm_next = SAT_LO[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r        <= '0;
      err_prev     <= '0;
      Position_pwm <= '0;
    end else begin
      err_r        <= err_now;
      err_prev     <= err_r;
      Position_pwm <= pwm_next;
    end
  end

endmodule

// File: tb/tb_position_pd_control.sv
// Bench for position_pd_control: error-history model with expected queue plus directed
// literal checks of step, approach, saturation, sign and reset behaviour.
module tb_position_pd_control;

  localparam int PWM_MAX   = 7200;
  localparam int OUT_SHIFT = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sensor = '0;
  logic [15:0] target = '0;
  logic [15:0] kp = '0;
  logic [15:0] kd = '0;
  logic [15:0] pwm;

  int n_checks = 0;
  int n_fail   = 0;

  position_pd_control #(.PWM_MAX(PWM_MAX), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk            (clk),
    .rst            (rst),
    .Sensor         (sensor),
    .positon_target (target),
    .posi_kp        (kp),
    .posi_kd        (kd),
    .Position_pwm   (pwm)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  // model: errors seen since the last reset, newest first
  longint      hist[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    longint e1, e2, raw;
    if (rst) begin
      hist.delete();
      exp_q.push_back(16'h0000);
    end else begin
      e1  = (hist.size() > 0) ? hist[0] : 64'sd0;
      e2  = (hist.size() > 1) ? hist[1] : 64'sd0;
      raw = (e1 * longint'(kp) + (e1 - e2) * longint'(kd)) >>> OUT_SHIFT;
      if (raw > PWM_MAX) raw = PWM_MAX;
      else if (raw < -PWM_MAX) raw = -PWM_MAX;
      exp_q.push_back(16'(raw));
      hist.push_front(longint'(sensor) - longint'(target));
      if (hist.size() > 2) void'(hist.pop_back());
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [15:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_checks++;
      if (pwm !== want) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got %h want %h", $time, pwm, want);
      end
    end
  end

  // driver tasks
  task automatic drive(input int s, input int t, input int p, input int d);
    sensor = 16'(s);
    target = 16'(t);
    kp     = 16'(p);
    kd     = 16'(d);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_lit(input string name, input int want);
    logic [15:0] w;
    w = 16'(want);
    n_checks++;
    if (pwm !== w) begin
      n_fail++;
      $display("FAIL %s: got %h (%0d) want %h (%0d)", name, pwm, $signed(pwm), w, want);
    end
  endtask

  int app_s[5]      = '{3000, 2500, 2200, 2100, 2075};
  int app_first[5]  = '{-1000, 0, -100, 0, 50};
  int app_steady[5] = '{1000, 500, 200, 100, 75};

  initial begin
    // reset held with arbitrary inputs, then released with zero inputs
    rst = 1'b1;
    drive(1234, 4321, 77, 88);
    cycles(3);
    check_lit("reset_hold", 0);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    cycles(3);
    check_lit("release_zero", 0);

    // step from reset: P 3000 + D 3000, then P only
    rst = 1'b1;
    cycles(1);
    check_lit("step_reset", 0);
    rst = 1'b0;
    drive(5000, 2000, 1, 1);
    cycles(2);
    check_lit("step_kick", 6000);
    cycles(1);
    check_lit("step_steady", 3000);
    cycles(3);

    // approach sequence, 10 cycles per point
    for (int i = 0; i < 5; i++) begin
      drive(app_s[i], 2000, 1, 1);
      cycles(2);
      check_lit($sformatf("approach_first_%0d", i), app_first[i]);
      cycles(1);
      check_lit($sformatf("approach_steady_%0d", i), app_steady[i]);
      cycles(7);
    end

    // saturation
    drive(5000, 2000, 10, 0);
    cycles(2);
    check_lit("sat_pos_first", 7200);
    cycles(1);
    check_lit("sat_pos", 7200);
    drive(0, 5000, 2, 0);
    cycles(2);
    check_lit("sat_neg", -7200);
    cycles(1);
    drive(65535, 0, 65535, 0);
    cycles(2);
    check_lit("sat_extreme_pos", 7200);
    drive(65535, 0, 65535, 65535);
    cycles(3);
    check_lit("sat_extreme_pos_kd", 7200);
    drive(0, 65535, 65535, 65535);
    cycles(2);
    check_lit("sat_extreme_neg_kick", -7200);
    cycles(1);
    check_lit("sat_extreme_neg", -7200);

    // zero gains
    drive(65535, 0, 0, 0);
    cycles(2);
    check_lit("zero_gain", 0);

    // negative error, no derivative
    drive(1000, 1500, 3, 0);
    cycles(2);
    check_lit("neg_err_first", 16'hFA24);
    cycles(1);
    check_lit("neg_err", -1500);

    // mid-run reset discards history
    drive(5000, 2000, 1, 1);
    cycles(2);
    check_lit("pre_reset_kick", 6500);
    cycles(3);
    check_lit("pre_reset_steady", 3000);
    rst = 1'b1;
    cycles(1);
    check_lit("midrun_reset", 0);
    rst = 1'b0;
    cycles(1);
    check_lit("post_reset_first", 0);
    cycles(1);
    check_lit("post_reset_kick", 6000);
    cycles(1);
    check_lit("post_reset_steady", 3000);
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
